// File: rtl/frog_hit_sequencer.sv
// Per-frame collision scheduler: scans the car table through one overlap comparator, then
// sequences explosion hold, life decrement, respawn and game over.
module frog_hit_sequencer #(
  parameter int unsigned NumCars         = 8,
  parameter int unsigned GridSize        = 32,
  parameter int unsigned ExplosionCycles = 1000000,
  parameter int unsigned StartLives      = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       game_restart_i,
  input  logic [9:0] frog_x_i,
  input  logic [9:0] frog_y_i,
  output logic [3:0] car_idx_o,
  input  logic [9:0] car_x_i,
  input  logic [4:0] car_row_i,
  input  logic       car_valid_i,
  output logic [3:0] hit_car_idx_o,
  output logic       scan_done_o,
  output logic       explosion_active_o,
  output logic       frog_freeze_o,
  output logic       respawn_o,
  output logic [2:0] lives_o,
  output logic       game_over_o
);

  localparam int unsigned     CntW     = $clog2(ExplosionCycles);
  localparam logic [CntW-1:0] CntLast  = CntW'(ExplosionCycles - 1);
  localparam logic [3:0]      IdxLast  = 4'(NumCars - 1);
  localparam logic [10:0]     Grid     = 11'(GridSize);
  localparam logic [2:0]      LivesIni = 3'(StartLives);

  typedef enum logic [2:0] {StIdle, StScan, StExplode, StRespawn, StGameOver} state_e;

  state_e          state_q;
  logic [3:0]      car_idx_q, cmp_idx_q, hit_idx_q;
  logic            cmp_vld_q, scan_done_q, respawn_q;
  logic [2:0]      lives_q;
  logic [CntW-1:0] cnt_q;

  logic [10:0] fx, fy, cx, cy;
  logic        hit;

  // Boxes overlap only with a strictly positive intersection on both axes.
  always_comb begin
    fx  = {1'b0, frog_x_i};
    fy  = {1'b0, frog_y_i};
    cx  = {1'b0, car_x_i};
    cy  = 11'(car_row_i) * Grid;
    hit = car_valid_i && (fx < cx + Grid) && (fx + Grid > cx) &&
          (fy < cy + Grid) && (fy + Grid > cy);
  end

  // cmp_idx_q names the slot whose table data is on the car inputs this clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      car_idx_q   <= '0;
      cmp_idx_q   <= '0;
      hit_idx_q   <= '0;
      cmp_vld_q   <= 1'b0;
      scan_done_q <= 1'b0;
      respawn_q   <= 1'b0;
      lives_q     <= LivesIni;
      cnt_q       <= '0;
    end else begin
      scan_done_q <= 1'b0;
      respawn_q   <= 1'b0;
      if (game_restart_i) begin
        lives_q   <= LivesIni;
        cnt_q     <= '0;
        car_idx_q <= '0;
        cmp_vld_q <= 1'b0;
        respawn_q <= 1'b1;
        state_q   <= StRespawn;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (frame_start_i) begin
              car_idx_q <= '0;
              cmp_vld_q <= 1'b0;
              state_q   <= StScan;
            end
          end
          StScan: begin
            if (cmp_vld_q && hit) begin
              hit_idx_q <= cmp_idx_q;
              if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
              cnt_q     <= '0;
              state_q   <= StExplode;
            end else if (cmp_vld_q && (cmp_idx_q == IdxLast)) begin
              scan_done_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              cmp_vld_q <= 1'b1;
              cmp_idx_q <= car_idx_q;
              if (car_idx_q != IdxLast) car_idx_q <= car_idx_q + 4'd1;
            end
          end
          StExplode: begin
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              if (lives_q != 3'd0) begin
                respawn_q <= 1'b1;
                state_q   <= StRespawn;
              end else begin
                state_q <= StGameOver;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRespawn:  state_q <= StIdle;
          StGameOver: state_q <= StGameOver;
          default:    state_q <= StIdle;
        endcase
      end
    end
  end

  assign car_idx_o          = car_idx_q;
  assign hit_car_idx_o      = hit_idx_q;
  assign scan_done_o        = scan_done_q;
  assign respawn_o          = respawn_q;
  assign lives_o            = lives_q;
  assign explosion_active_o = (state_q == StExplode);
  assign game_over_o        = (state_q == StGameOver);
  assign frog_freeze_o      = (state_q == StExplode) || (state_q == StRespawn) ||
                              (state_q == StGameOver);

endmodule

// File: tb/tb_frog_hit_sequencer.sv
// Bench for frog_hit_sequencer: table of car layouts run frame by frame through a scoreboard,
// plus hand sequences for game over, restart mid-explosion, restart/frame collision and reset.
module tb_frog_hit_sequencer;
  localparam int NC = 4;
  localparam int EC = 8;
  localparam int SL = 3;

  logic       clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, game_restart = 1'b0;
  logic [9:0] frog_x = 10'd100, frog_y = 10'd100;
  logic [3:0] car_idx, hit_car_idx;
  logic [9:0] car_x = '0;
  logic [4:0] car_row = '0;
  logic       car_valid = 1'b0;
  logic       scan_done, explosion, freeze, respawn, game_over;
  logic [2:0] lives;

  logic [9:0] cx[NC];
  logic [4:0] crow[NC];
  logic       cv[NC];

  frog_hit_sequencer #(
    .NumCars(NC), .GridSize(32), .ExplosionCycles(EC), .StartLives(SL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(frame_start), .game_restart_i(game_restart),
    .frog_x_i(frog_x), .frog_y_i(frog_y), .car_idx_o(car_idx), .car_x_i(car_x),
    .car_row_i(car_row), .car_valid_i(car_valid), .hit_car_idx_o(hit_car_idx),
    .scan_done_o(scan_done), .explosion_active_o(explosion), .frog_freeze_o(freeze),
    .respawn_o(respawn), .lives_o(lives), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  // Car table with a one-clock registered read.
  always @(posedge clk) begin
    car_x     <= cx[car_idx[1:0]];
    car_row   <= crow[car_idx[1:0]];
    car_valid <= cv[car_idx[1:0]];
  end

  int total = 0;
  int bad = 0;
  int exp_lives = SL;

  typedef struct {
    logic [9:0] x[NC];
    logic [4:0] row[NC];
    logic       v[NC];
    logic       hit;
    logic [3:0] idx;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    int         lat;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic vec_t base_vec();
    vec_t v;
    for (int i = 0; i < NC; i++) begin
      v.x[i] = 10'd300; v.row[i] = 5'd0; v.v[i] = 1'b1;
    end
    v.hit = 1'b0; v.idx = 4'd0;
    return v;
  endfunction

  task automatic load_cars(input vec_t v);
    for (int i = 0; i < NC; i++) begin
      cx[i] = v.x[i]; crow[i] = v.row[i]; cv[i] = v.v[i];
    end
  endtask

  task automatic run_frame(input string nm, input vec_t v);
    exp_t e;
    int   lat;
    int   n;
    bit   seen;
    e.hit = v.hit; e.idx = v.idx; e.lat = v.hit ? int'(v.idx) + 2 : NC + 1;
    sb.push_back(e);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (scan_done || explosion) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      chk({nm, " timeout"}, 0, 1);
      return;
    end
    chk({nm, " hit"}, 32'(explosion), 32'(e.hit));
    chk({nm, " latency"}, lat, e.lat);
    if (e.hit) begin
      if (exp_lives > 0) exp_lives--;
      chk({nm, " hit idx"}, 32'(hit_car_idx), 32'(e.idx));
      chk({nm, " lives"}, 32'(lives), exp_lives);
      chk({nm, " freeze"}, 32'(freeze), 1);
      n = 0;
      while (explosion && n < 30) begin
        n++;
        @(negedge clk);
      end
      chk({nm, " explode len"}, n, EC);
      if (exp_lives != 0) begin
        chk({nm, " respawn"}, 32'(respawn), 1);
        @(negedge clk);
        chk({nm, " respawn pulse"}, 32'(respawn), 0);
        chk({nm, " unfreeze"}, 32'(freeze), 0);
      end else begin
        chk({nm, " no respawn"}, 32'(respawn), 0);
        chk({nm, " game over"}, 32'(game_over), 1);
        chk({nm, " go freeze"}, 32'(freeze), 1);
      end
    end else begin
      chk({nm, " lives"}, 32'(lives), exp_lives);
      @(negedge clk);
      chk({nm, " done pulse"}, 32'(scan_done), 0);
    end
  endtask

  initial begin
    bit leak;
    int n;
    for (int i = 0; i < 9; i++) vecs[i] = base_vec();
    vecs[1].x[2] = 10'd90;  vecs[1].row[2] = 5'd3; vecs[1].hit = 1'b1; vecs[1].idx = 4'd2;
    vecs[2].x[1] = 10'd132; vecs[2].row[1] = 5'd3;
    vecs[3].x[1] = 10'd131; vecs[3].row[1] = 5'd3; vecs[3].hit = 1'b1; vecs[3].idx = 4'd1;
    vecs[4].x[0] = 10'd100; vecs[4].row[0] = 5'd3; vecs[4].v[0] = 1'b0;
    vecs[5].x[2] = 10'd110; vecs[5].row[2] = 5'd3; vecs[5].hit = 1'b1; vecs[5].idx = 4'd2;
    vecs[5].x[3] = 10'd95;  vecs[5].row[3] = 5'd3;
    vecs[6].x[0] = 10'd68;  vecs[6].row[0] = 5'd3;
    vecs[7].x[3] = 10'd100; vecs[7].row[3] = 5'd4; vecs[7].hit = 1'b1; vecs[7].idx = 4'd3;
    vecs[8].x[3] = 10'd100; vecs[8].row[3] = 5'd2;
    load_cars(vecs[0]);

    repeat (3) @(negedge clk);
    chk("rst car_idx", 32'(car_idx), 0);
    chk("rst hit_idx", 32'(hit_car_idx), 0);
    chk("rst lives", 32'(lives), SL);
    chk("rst bits", {27'd0, scan_done, explosion, freeze, respawn, game_over}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      load_cars(vecs[i]);
      run_frame($sformatf("vec%0d", i), vecs[i]);
      if (exp_lives == 0) begin
        leak = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (8) begin
          if (scan_done || explosion || !game_over) leak = 1'b1;
          @(negedge clk);
        end
        chk("gameover ignores frame", 32'(leak), 0);
        game_restart = 1'b1;
        @(negedge clk);
        game_restart = 1'b0;
        exp_lives = SL;
        chk("restart respawn", 32'(respawn), 1);
        chk("restart lives", 32'(lives), SL);
        chk("restart game_over", 32'(game_over), 0);
        @(negedge clk);
        chk("restart unfreeze", 32'(freeze), 0);
      end
    end

    // Restart on the fourth explosion cycle.
    load_cars(vecs[1]);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    while (!explosion && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("midexp started", 32'(explosion), 1);
    chk("midexp lives", 32'(lives), exp_lives - 1);
    repeat (3) @(negedge clk);
    game_restart = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    exp_lives = SL;
    chk("midexp ended", 32'(explosion), 0);
    chk("midexp lives reload", 32'(lives), SL);
    chk("midexp respawn", 32'(respawn), 1);
    @(negedge clk);
    chk("midexp respawn pulse", 32'(respawn), 0);

    // Restart and frame start together: restart wins, no scan follows.
    frame_start = 1'b1; game_restart = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; game_restart = 1'b0;
    chk("both respawn", 32'(respawn), 1);
    leak = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (scan_done || explosion) leak = 1'b1;
    end
    chk("both no scan", 32'(leak), 0);

    // Asynchronous reset in the middle of a scan that would hit.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst car_idx", 32'(car_idx), 0);
    chk("arst lives", 32'(lives), SL);
    chk("arst bits", {27'd0, scan_done, explosion, freeze, respawn, game_over}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    leak = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (scan_done || explosion || respawn) leak = 1'b1;
    end
    chk("arst no pulse", 32'(leak), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
